// File: rtl/alu_and_alu_control.sv
// MIPS-style execute-stage block.
// The ALU-control decoder turns ALU_Op and FuncCode into a 4-bit ALUCtl code.
// That code drives a 32-bit ALU whose result is registered into Output and Zero_Flag.
// Optional feature macro: ALU_OVERFLOW_EN. When it is defined, the block adds a
// registered signed-overflow output named Overflow.
// Reset is asynchronous and active-low on rst_n.

module alu_and_alu_control #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       FuncCode,
    input  logic [1:0]       ALU_Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Output,
    output logic             Zero_Flag
`ifdef ALU_OVERFLOW_EN
    ,
    output logic             Overflow
`endif
);

    // ALUCtl encodings. These are the classic MIPS codes; CtlInvalid is an
    // otherwise-unused code.
    typedef enum logic [3:0] {
        CtlAnd     = 4'b0000,
        CtlOr      = 4'b0001,
        CtlAdd     = 4'b0010,
        CtlSub     = 4'b0110,
        CtlSlt     = 4'b0111,
        CtlNor     = 4'b1100,
        CtlInvalid = 4'b1111
    } alu_ctl_e;

    // Main-control ALU_Op encodings
    localparam logic [1:0] OpAdd     = 2'b00;
    localparam logic [1:0] OpSub     = 2'b01;
    localparam logic [1:0] OpRType   = 2'b10;
    localparam logic [1:0] OpInvalid = 2'b11;

    // R-type funct field encodings
    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctAnd = 6'b100100;
    localparam logic [5:0] FunctOr  = 6'b100101;
    localparam logic [5:0] FunctSlt = 6'b101010;
    localparam logic [5:0] FunctNor = 6'b100111;

    alu_ctl_e         w_alu_ctl;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic             w_slt;
    logic [WIDTH-1:0] w_result;
    logic             w_zero;

    logic [WIDTH-1:0] r_output;
    logic             r_zero;

    // Decode ALU_Op and FuncCode into the ALU control code
    always_comb begin
        w_alu_ctl = CtlInvalid;
        unique case (ALU_Op)
            OpAdd:     w_alu_ctl = CtlAdd;
            OpSub:     w_alu_ctl = CtlSub;
            OpRType: begin
                unique case (FuncCode)
                    FunctAdd: w_alu_ctl = CtlAdd;
                    FunctSub: w_alu_ctl = CtlSub;
                    FunctAnd: w_alu_ctl = CtlAnd;
                    FunctOr:  w_alu_ctl = CtlOr;
                    FunctSlt: w_alu_ctl = CtlSlt;
                    FunctNor: w_alu_ctl = CtlNor;
                    default:  w_alu_ctl = CtlInvalid;
                endcase
            end
            OpInvalid: w_alu_ctl = CtlInvalid;
            default:   w_alu_ctl = CtlInvalid;
        endcase
    end

    // Arithmetic datapath shared by the result mux and the overflow detector
    always_comb begin
        w_sum  = A + B;
        w_diff = A - B;
        w_slt  = ($signed(A) < $signed(B));
    end

    // Select the ALU result; invalid codes produce zero (and so set Zero_Flag)
    always_comb begin
        w_result = '0;
        unique case (w_alu_ctl)
            CtlAdd:     w_result = w_sum;
            CtlSub:     w_result = w_diff;
            CtlAnd:     w_result = A & B;
            CtlOr:      w_result = A | B;
            CtlNor:     w_result = ~(A | B);
            CtlSlt:     w_result = {{(WIDTH-1){1'b0}}, w_slt};
            CtlInvalid: w_result = '0;
            default:    w_result = '0;
        endcase
    end

    // Zero detect on the same result that is about to be registered
    always_comb begin
        w_zero = (w_result == '0);
    end

`ifdef ALU_OVERFLOW_EN
    logic w_overflow;
    logic r_overflow;

    // Signed overflow: ADD when operand signs match but the result sign flips;
    // SUB when operand signs differ and the result sign differs from A
    always_comb begin
        w_overflow = 1'b0;
        unique case (w_alu_ctl)
            CtlAdd:  w_overflow = (A[WIDTH-1] == B[WIDTH-1]) &&
                                  (w_sum[WIDTH-1] != A[WIDTH-1]);
            CtlSub:  w_overflow = (A[WIDTH-1] != B[WIDTH-1]) &&
                                  (w_diff[WIDTH-1] != A[WIDTH-1]);
            default: w_overflow = 1'b0;
        endcase
    end

    // Overflow is registered alongside Output; Output is never suppressed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_overflow;
        end
    end

    assign Overflow = r_overflow;
`endif

    // EX/MEM capture: one cycle of latency, with no stall or handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_output <= '0;
            r_zero   <= 1'b0;
        end else begin
            r_output <= w_result;
            r_zero   <= w_zero;
        end
    end

    assign Output    = r_output;
    assign Zero_Flag = r_zero;

endmodule

// File: tb/tb_alu_and_alu_control.sv
// Directed testbench for alu_and_alu_control.
// Build with +define+ALU_OVERFLOW_EN to also cover the Overflow output.

module tb_alu_and_alu_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  FuncCode;
    logic [1:0]  ALU_Op;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] Output;
    logic        Zero_Flag;
`ifdef ALU_OVERFLOW_EN
    logic        Overflow;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [31:0] OpA = 32'h12737398;
    localparam logic [31:0] OpB = 32'h12737399;

    always #5 clk = ~clk;

    alu_and_alu_control #(
        .WIDTH(32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .FuncCode (FuncCode),
        .ALU_Op   (ALU_Op),
        .A        (A),
        .B        (B),
        .Output   (Output),
        .Zero_Flag(Zero_Flag)
`ifdef ALU_OVERFLOW_EN
        ,
        .Overflow (Overflow)
`endif
    );

    // Drive on the falling edge, then sample 1ns after the next rising edge
    task automatic drive(input logic [1:0] op, input logic [5:0] fc,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        ALU_Op   = op;
        FuncCode = fc;
        A        = a;
        B        = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        ALU_Op   = 2'b10;
        FuncCode = 6'b100000;
        A        = OpA;
        B        = OpB;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (Output !== 32'h0) begin
            n_fails++;
            $display("FAIL reset_output: got %h expected %h", Output, 32'h0);
        end
        n_checks++;
        if (Zero_Flag !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_zero: got %b expected 0", Zero_Flag);
        end
`ifdef ALU_OVERFLOW_EN
        n_checks++;
        if (Overflow !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_overflow: got %b expected 0", Overflow);
        end
`endif
        // Release; the first edge captures the inputs already present
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (Output !== 32'h24E6E731) begin
            n_fails++;
            $display("FAIL reset_release_capture: got %h expected %h", Output, 32'h24E6E731);
        end
        // Mid-cycle reset clears the outputs with no clock edge
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (Output !== 32'h0 || Zero_Flag !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_async: got %h/%b expected 00000000/0", Output, Zero_Flag);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_rtype();
        logic [5:0]  fc_tab  [6];
        logic [31:0] exp_tab [6];
        fc_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
        exp_tab = '{32'h24E6E731, 32'hFFFFFFFF, 32'h12737398, 32'h12737399,
                    32'h00000001, 32'hED8C8C66};
        for (int i = 0; i < 6; i++) begin
            drive(2'b10, fc_tab[i], OpA, OpB);
            n_checks++;
            if (Output !== exp_tab[i] || Zero_Flag !== 1'b0) begin
                n_fails++;
                $display("FAIL rtype_funct_%b: got %h/%b expected %h/0",
                         fc_tab[i], Output, Zero_Flag, exp_tab[i]);
            end
        end
    endtask

    task automatic test_aluop_override();
        drive(2'b00, 6'b111111, OpA, OpB);
        n_checks++;
        if (Output !== 32'h24E6E731 || Zero_Flag !== 1'b0) begin
            n_fails++;
            $display("FAIL aluop00_add: got %h/%b expected 24e6e731/0", Output, Zero_Flag);
        end
        drive(2'b01, 6'b111111, OpA, OpB);
        n_checks++;
        if (Output !== 32'hFFFFFFFF || Zero_Flag !== 1'b0) begin
            n_fails++;
            $display("FAIL aluop01_sub: got %h/%b expected ffffffff/0", Output, Zero_Flag);
        end
        drive(2'b01, 6'b111111, OpA, OpA);
        n_checks++;
        if (Output !== 32'h0 || Zero_Flag !== 1'b1) begin
            n_fails++;
            $display("FAIL aluop01_equal: got %h/%b expected 00000000/1", Output, Zero_Flag);
        end
    endtask

    task automatic test_invalid();
        logic [5:0] fc_tab [3];
        fc_tab = '{6'b000000, 6'b100000, 6'b111111};
        // Put a nonzero value in the register first so a stale zero cannot pass
        drive(2'b00, 6'b000000, OpA, OpB);
        drive(2'b10, 6'b000000, OpA, OpB);
        n_checks++;
        if (Output !== 32'h0 || Zero_Flag !== 1'b1) begin
            n_fails++;
            $display("FAIL invalid_funct: got %h/%b expected 00000000/1", Output, Zero_Flag);
        end
        for (int i = 0; i < 3; i++) begin
            drive(2'b00, 6'b000000, OpA, OpB);
            drive(2'b11, fc_tab[i], OpA, OpB);
            n_checks++;
            if (Output !== 32'h0 || Zero_Flag !== 1'b1) begin
                n_fails++;
                $display("FAIL invalid_aluop11_fc%b: got %h/%b expected 00000000/1",
                         fc_tab[i], Output, Zero_Flag);
            end
        end
    endtask

    task automatic test_slt_signed();
        drive(2'b10, 6'b101010, 32'h80000000, 32'h00000001);
        n_checks++;
        if (Output !== 32'h1 || Zero_Flag !== 1'b0) begin
            n_fails++;
            $display("FAIL slt_neg_lt_pos: got %h/%b expected 00000001/0", Output, Zero_Flag);
        end
        drive(2'b10, 6'b101010, 32'h00000001, 32'h80000000);
        n_checks++;
        if (Output !== 32'h0 || Zero_Flag !== 1'b1) begin
            n_fails++;
            $display("FAIL slt_pos_lt_neg: got %h/%b expected 00000000/1", Output, Zero_Flag);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op_tab  [5];
        logic [5:0]  fc_tab  [5];
        logic [31:0] a_tab   [5];
        logic [31:0] b_tab   [5];
        logic [31:0] exp_tab [5];
        logic        z_tab   [5];
        op_tab  = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10};
        fc_tab  = '{6'b000000, 6'b000000, 6'b100101, 6'b100111, 6'b100010};
        a_tab   = '{32'h5, 32'h5, 32'hF0, 32'h0, 32'h7};
        b_tab   = '{32'h3, 32'h3, 32'h0F, 32'h0, 32'h7};
        exp_tab = '{32'h8, 32'h2, 32'hFF, 32'hFFFFFFFF, 32'h0};
        z_tab   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            drive(op_tab[i], fc_tab[i], a_tab[i], b_tab[i]);
            n_checks++;
            if (Output !== exp_tab[i] || Zero_Flag !== z_tab[i]) begin
                n_fails++;
                $display("FAIL back_to_back_%0d: got %h/%b expected %h/%b",
                         i, Output, Zero_Flag, exp_tab[i], z_tab[i]);
            end
        end
    endtask

`ifdef ALU_OVERFLOW_EN
    task automatic test_overflow();
        drive(2'b00, 6'b000000, 32'h7FFFFFFF, 32'h00000001);
        n_checks++;
        if (Output !== 32'h80000000 || Overflow !== 1'b1) begin
            n_fails++;
            $display("FAIL ovf_add: got %h/%b expected 80000000/1", Output, Overflow);
        end
        drive(2'b01, 6'b000000, 32'h80000000, 32'h00000001);
        n_checks++;
        if (Output !== 32'h7FFFFFFF || Overflow !== 1'b1) begin
            n_fails++;
            $display("FAIL ovf_sub: got %h/%b expected 7fffffff/1", Output, Overflow);
        end
        drive(2'b10, 6'b100100, 32'h7FFFFFFF, 32'h7FFFFFFF);
        n_checks++;
        if (Output !== 32'h7FFFFFFF || Overflow !== 1'b0) begin
            n_fails++;
            $display("FAIL ovf_and: got %h/%b expected 7fffffff/0", Output, Overflow);
        end
        drive(2'b00, 6'b000000, 32'h00000001, 32'h00000001);
        n_checks++;
        if (Output !== 32'h2 || Overflow !== 1'b0) begin
            n_fails++;
            $display("FAIL ovf_add_none: got %h/%b expected 00000002/0", Output, Overflow);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rtype();
        test_aluop_override();
        test_invalid();
        test_slt_signed();
        test_back_to_back();
`ifdef ALU_OVERFLOW_EN
        test_overflow();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
